// File: rtl/mvau_stream_sequencer.sv
// rtl/mvau_stream_sequencer.sv - MVAU stream sequencer: input-buffer fill/reuse, weight address, fold flush
// One chunk per step; the first neuron fold writes the buffer, later folds replay it.
module mvau_stream_sequencer #(
    parameter int SF           = 8,
    parameter int NF           = 2,
    parameter int SF_T         = 3,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_v,
    output logic                    in_rdy,
    input  logic                    out_rdy,
    output logic                    out_v,
    output logic                    ib_wen,
    output logic                    ib_ren,
    output logic [SF_T-1:0]         ib_addr,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    step,
    output logic                    sf_clr
);
    localparam int NF_T = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SF_T-1:0]         SF_LAST   = SF_T'(SF - 1);
    localparam logic [NF_T-1:0]         NF_LAST   = NF_T'(NF - 1);
    localparam logic [WMEM_ADDR_BW-1:0] WMEM_LAST = WMEM_ADDR_BW'(SF * NF - 1);

    typedef enum logic {FILL = 1'b0, REUSE = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic [SF_T-1:0]           sf_cnt_q, sf_cnt_d;
    logic [NF_T-1:0]           nf_cnt_q, nf_cnt_d;
    logic [WMEM_ADDR_BW-1:0]   wmem_addr_q, wmem_addr_d;
    logic                      out_v_q, out_v_d;
    logic                      stall;
    logic                      fill;

    always_comb begin
        fill   = (state_q == FILL);
        stall  = out_v_q & ~out_rdy;
        // in_rdy must not depend on in_v to keep the upstream handshake loop-free
        in_rdy = fill & ~stall;
        step   = ~stall & (fill ? in_v : 1'b1);
        ib_wen = step & fill;
        ib_ren = step & ~fill;
        sf_clr = step & (sf_cnt_q == SF_LAST);

        state_d     = state_q;
        sf_cnt_d    = sf_cnt_q;
        nf_cnt_d    = nf_cnt_q;
        wmem_addr_d = wmem_addr_q;

        if (step) begin
            sf_cnt_d    = sf_clr ? '0 : sf_cnt_q + 1'b1;
            wmem_addr_d = (wmem_addr_q == WMEM_LAST) ? '0 : wmem_addr_q + 1'b1;
        end
        if (sf_clr) begin
            nf_cnt_d = (nf_cnt_q == NF_LAST) ? '0 : nf_cnt_q + 1'b1;
            if (fill && (NF > 1)) begin
                state_d = REUSE;
            end else if (!fill && (nf_cnt_q == NF_LAST)) begin
                state_d = FILL;
            end
        end

        // A new fold result overrides the clear of the one being handed off
        if (sf_clr) begin
            out_v_d = 1'b1;
        end else if (out_rdy) begin
            out_v_d = 1'b0;
        end else begin
            out_v_d = out_v_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            sf_cnt_q    <= '0;
            nf_cnt_q    <= '0;
            wmem_addr_q <= '0;
            out_v_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sf_cnt_q    <= sf_cnt_d;
            nf_cnt_q    <= nf_cnt_d;
            wmem_addr_q <= wmem_addr_d;
            out_v_q     <= out_v_d;
        end
    end

    assign ib_addr   = sf_cnt_q;
    assign wmem_addr = wmem_addr_q;
    assign out_v     = out_v_q;

    a_wmem_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        int'(wmem_addr_q) == int'(nf_cnt_q) * SF + int'(sf_cnt_q));

endmodule

// File: tb/tb_mvau_stream_sequencer.sv
// tb/tb_mvau_stream_sequencer.sv - self-checking bench over four SF/NF configurations of the sequencer
module tb_mvau_stream_sequencer;
    localparam int NI = 4;
    localparam int SFS [NI] = '{4, 3, 1, 8};
    localparam int NFS [NI] = '{2, 1, 3, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_v = 1'b0;
    logic out_rdy = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0] d_in_rdy, d_out_v, d_wen, d_ren, d_step, d_clr;
    logic [31:0]   d_wmem [NI];
    logic [31:0]   d_ib   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int SFG = SFS[g];
        localparam int NFG = NFS[g];
        localparam int SFT = (SFG > 1) ? $clog2(SFG) : 1;
        localparam int WBW = (SFG * NFG > 1) ? $clog2(SFG * NFG) : 1;
        logic [SFT-1:0] ib_addr_w;
        logic [WBW-1:0] wmem_w;
        mvau_stream_sequencer #(.SF(SFG), .NF(NFG), .SF_T(SFT), .WMEM_ADDR_BW(WBW)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(d_in_rdy[g]),
            .out_rdy(out_rdy), .out_v(d_out_v[g]), .ib_wen(d_wen[g]), .ib_ren(d_ren[g]),
            .ib_addr(ib_addr_w), .wmem_addr(wmem_w), .step(d_step[g]), .sf_clr(d_clr[g])
        );
        assign d_wmem[g] = 32'(wmem_w);
        assign d_ib[g]   = 32'(ib_addr_w);
    end

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference model: single position counter p over the SF*NF chunks of a vector
    int m_p [NI];
    int m_ov [NI];
    int sb_q [NI][$];
    int push_ord [NI];
    int hs_ord [NI];
    int c_clr [NI], c_hs [NI], c_wen [NI], c_ren [NI];

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [5:0] flags;  // {in_rdy, out_v, ib_wen, ib_ren, step, sf_clr}
        int         wmem;
        int         ib;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_p[i] = 0;
            m_ov[i] = 0;
            sb_q[i].delete();
            push_ord[i] = 0;
            hs_ord[i] = 0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NI; i++) begin
            c_clr[i] = 0; c_hs[i] = 0; c_wen[i] = 0; c_ren[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            automatic int  sf = SFS[i];
            automatic bit  fl = (m_p[i] < sf);
            automatic bit  st = (m_ov[i] != 0) && !out_rdy;
            automatic bit  sp = !st && (fl ? in_v : 1'b1);
            automatic bit  cl = sp && ((m_p[i] % sf) == sf - 1);
            automatic logic [5:0] ef = {fl && !st, m_ov[i] != 0, sp && fl, sp && !fl, sp, cl};
            automatic logic [5:0] af = {d_in_rdy[i], d_out_v[i], d_wen[i], d_ren[i], d_step[i], d_clr[i]};
            n_vec++;
            if (ef !== af || d_wmem[i] != m_p[i] || d_ib[i] != (m_p[i] % sf)) begin
                n_fail++;
                $display("FAIL outputs inst%0d cyc%0d: got flags=%b wmem=%0d ib=%0d, want flags=%b wmem=%0d ib=%0d",
                         i, cyc, af, d_wmem[i], d_ib[i], ef, m_p[i], m_p[i] % sf);
            end
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < NI; i++) begin
            automatic int  sf = SFS[i];
            automatic int  len = SFS[i] * NFS[i];
            automatic bit  fl = (m_p[i] < sf);
            automatic bit  st = (m_ov[i] != 0) && !out_rdy;
            automatic bit  sp = !st && (fl ? in_v : 1'b1);
            automatic bit  cl = sp && ((m_p[i] % sf) == sf - 1);
            if (d_out_v[i] && out_rdy) begin
                c_hs[i]++;
                if (sb_q[i].size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sb_unexpected inst%0d cyc%0d: got handshake, want none", i, cyc);
                end else begin
                    chk($sformatf("sb_order%0d", i), sb_q[i].pop_front(), hs_ord[i]);
                end
                hs_ord[i]++;
            end
            if (cl) begin
                sb_q[i].push_back(push_ord[i]);
                push_ord[i]++;
            end
            if (d_clr[i]) c_clr[i]++;
            if (d_wen[i]) c_wen[i]++;
            if (d_ren[i]) c_ren[i]++;
            if (sp) m_p[i] = (m_p[i] + 1) % len;
            if (cl) m_ov[i] = 1;
            else if (out_rdy) m_ov[i] = 0;
        end
        cyc++;
    endtask

    task automatic drive(input logic iv, input logic ordy);
        @(negedge clk);
        in_v = iv;
        out_rdy = ordy;
        #1;
    endtask

    task automatic run_cycle(input logic iv, input logic ordy);
        drive(iv, ordy);
        check_outputs();
        update_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_v = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 6'b101010, 0, 0};
        tbl[1] = '{1'b1, 1'b1, 6'b101010, 1, 1};
        tbl[2] = '{1'b1, 1'b1, 6'b101010, 2, 2};
        tbl[3] = '{1'b1, 1'b1, 6'b101011, 3, 3};
        tbl[4] = '{1'b1, 1'b1, 6'b010110, 4, 0};
        tbl[5] = '{1'b1, 1'b1, 6'b000110, 5, 1};
        tbl[6] = '{1'b1, 1'b1, 6'b000110, 6, 2};
        tbl[7] = '{1'b1, 1'b1, 6'b000111, 7, 3};
        tbl[8] = '{1'b1, 1'b1, 6'b111010, 0, 0};
        tbl[9] = '{1'b1, 1'b1, 6'b101010, 1, 1};

        model_reset();
        clear_counts();
        #1;
        chk("reset_out_v", d_out_v[0], 0);
        chk("reset_wmem", d_wmem[0], 0);
        chk("reset_in_rdy", d_in_rdy[0], 1);
        do_reset();

        // continuous streaming, SF=4 NF=2 against the fixed table
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].iv, tbl[k].ordy);
            n_vec++;
            if ({d_in_rdy[0], d_out_v[0], d_wen[0], d_ren[0], d_step[0], d_clr[0]} !== tbl[k].flags ||
                d_wmem[0] != tbl[k].wmem || d_ib[0] != tbl[k].ib) begin
                n_fail++;
                $display("FAIL table row%0d: got flags=%b wmem=%0d ib=%0d, want flags=%b wmem=%0d ib=%0d",
                         k, {d_in_rdy[0], d_out_v[0], d_wen[0], d_ren[0], d_step[0], d_clr[0]},
                         d_wmem[0], d_ib[0], tbl[k].flags, tbl[k].wmem, tbl[k].ib);
            end
            check_outputs();
            update_model();
        end

        // in_v gap on cycle 2 only
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(k != 2, 1'b1);
            if (k == 3) chk("gap_clr_c3", d_clr[0], 0);
            if (k == 4) chk("gap_clr_c4", d_clr[0], 1);
            if (k == 5) chk("gap_reuse_ren", d_ren[0], 1);
            check_outputs();
            update_model();
        end

        // downstream backpressure for three cycles after the first out_v
        do_reset();
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, !(k >= 4 && k <= 6));
            if (k == 5) begin
                chk("stall_wmem", d_wmem[0], 4);
                chk("stall_step", d_step[0], 0);
                chk("stall_in_rdy", d_in_rdy[0], 0);
            end
            if (k == 7) chk("resume_wmem", d_wmem[0], 4);
            check_outputs();
            update_model();
        end

        // asynchronous reset at sf_cnt=2, nf_cnt=1
        do_reset();
        repeat (6) run_cycle(1'b1, 1'b1);
        @(negedge clk);
        in_v = 1'b1;
        out_rdy = 1'b1;
        #1;
        chk("prerst_wmem", d_wmem[0], 6);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_wmem", d_wmem[0], 0);
        chk("arst_ib", d_ib[0], 0);
        chk("arst_out_v", d_out_v[0], 0);
        chk("arst_in_rdy", d_in_rdy[0], 1);
        chk("arst_ren", d_ren[0], 0);
        check_outputs();
        @(negedge clk);
        in_v = 1'b0;
        rst_n = 1'b1;
        cyc = 0;
        drive(1'b1, 1'b1);
        chk("post_rst_wen", d_wen[0], 1);
        chk("post_rst_wmem", d_wmem[0], 0);
        check_outputs();
        update_model();

        // random in_v / out_rdy
        do_reset();
        clear_counts();
        for (int k = 0; k < 10000; k++) begin
            run_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < NI; i++) begin
            automatic int sf = SFS[i];
            automatic int nf = NFS[i];
            automatic int vecs = c_clr[i] / nf;
            chk($sformatf("rand_hs%0d", i), c_hs[i], c_clr[i] - m_ov[i]);
            chk($sformatf("rand_wen%0d", i), c_wen[i], sf * vecs + ((m_p[i] < sf) ? m_p[i] : sf));
            chk($sformatf("rand_ren%0d", i), c_ren[i],
                sf * (nf - 1) * vecs + ((m_p[i] > sf) ? m_p[i] - sf : 0));
        end
        chk("rand_nf1_no_ren", c_ren[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
